// File: rtl/fetch_unit.sv
// Instruction fetch stage: turns a one-cycle fetch request into an address/data
// handshake on the instruction bus and returns the word to the decoder.
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_fetch,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [ADDR_WIDTH-1:0] ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [DATA_WIDTH-1:0] ir_data,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  inst_misaligned,
    output logic                  fetch_overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ir_addr_q, ir_addr_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic                    misaligned_q, misaligned_d;
    logic                    overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        ir_addr_d    = ir_addr_q;
        inst_d       = inst_q;
        misaligned_d = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (inst_fetch) begin
                    if (pc[1:0] == 2'b00) begin
                        ir_addr_d = pc;
                        state_d   = ADDR;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (ir_addr_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ir_data_valid) begin
                    inst_d  = ir_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Requests are never queued; a request while busy only raises the sticky flag.
        if (inst_fetch && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ir_addr_q    <= '0;
            inst_q       <= '0;
            misaligned_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_addr_q    <= ir_addr_d;
            inst_q       <= inst_d;
            misaligned_q <= misaligned_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ir_addr_valid   = (state_q == ADDR);
    assign ir_data_ready   = (state_q == DATA);
    assign inst_valid      = (state_q == RESP);
    assign ir_addr         = ir_addr_q;
    assign inst            = inst_q;
    assign inst_misaligned = misaligned_q;
    assign fetch_overrun   = overrun_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_fetch;
    logic [31:0] pc;
    logic        ir_addr_valid;
    logic        ir_addr_ready;
    logic [31:0] ir_addr;
    logic        ir_data_valid;
    logic        ir_data_ready;
    logic [31:0] ir_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_misaligned;
    logic        fetch_overrun;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_fetch     (inst_fetch),
        .pc             (pc),
        .ir_addr_valid  (ir_addr_valid),
        .ir_addr_ready  (ir_addr_ready),
        .ir_addr        (ir_addr),
        .ir_data_valid  (ir_data_valid),
        .ir_data_ready  (ir_data_ready),
        .ir_data        (ir_data),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst_misaligned(inst_misaligned),
        .fetch_overrun  (fetch_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding request with progress flags; outputs follow from them.
    bit          m_busy, m_addr_done, m_data_done, m_mis, m_ovr;
    logic [31:0] m_addr, m_inst;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_addr_done = 0; m_data_done = 0; m_mis = 0; m_ovr = 0;
            m_addr = '0; m_inst = '0;
        end else begin
            m_mis = 0;
            if (!m_busy) begin
                if (inst_fetch) begin
                    if (pc[1:0] != 2'b00) m_mis = 1;
                    else begin
                        m_busy = 1; m_addr = pc; m_addr_done = 0; m_data_done = 0;
                    end
                end
            end else begin
                if (inst_fetch) m_ovr = 1;
                if (m_data_done) m_busy = 0;
                else if (m_addr_done) begin
                    if (ir_data_valid) begin
                        m_inst = ir_data; m_data_done = 1;
                    end
                end else if (ir_addr_ready) m_addr_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("addr_valid", 32'(ir_addr_valid), 32'(m_busy && !m_addr_done));
        check("data_ready", 32'(ir_data_ready), 32'(m_busy && m_addr_done && !m_data_done));
        check("inst_valid", 32'(inst_valid), 32'(m_busy && m_data_done));
        check("ir_addr", ir_addr, m_addr);
        check("inst", inst, m_inst);
        check("misaligned", 32'(inst_misaligned), 32'(m_mis));
        check("overrun", 32'(fetch_overrun), 32'(m_ovr));
    end

    // Drive one cycle's inputs shortly after the edge, return once outputs are settled.
    task automatic drive(input logic r, input logic f, input logic [31:0] p,
                         input logic ar, input logic dv, input logic [31:0] d);
        @(posedge clk);
        #2;
        rst = r; inst_fetch = f; pc = p; ir_addr_ready = ar; ir_data_valid = dv; ir_data = d;
        @(negedge clk);
    endtask

    int unsigned iv_cnt;
    int unsigned av_cnt;

    initial begin
        rst = 1'b1; inst_fetch = 0; pc = '0; ir_addr_ready = 0; ir_data_valid = 0; ir_data = '0;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("rst_addr_valid", 32'(ir_addr_valid), 0);
        check("rst_data_ready", 32'(ir_data_ready), 0);
        check("rst_inst", inst, 0);
        check("rst_ir_addr", ir_addr, 0);
        check("rst_flags", {29'd0, inst_valid, inst_misaligned, fetch_overrun}, 0);

        // Zero-wait fetch
        iv_cnt = 0;
        for (int c = 0; c <= 5; c++) begin
            drive(0, c == 0, 32'h100, 1, 1, 32'h0050_0093);
            if (inst_valid) iv_cnt++;
            if (c == 1) check("zw_ir_addr", ir_addr, 32'h100);
            if (c == 3) check("zw_iv_c3", 32'(inst_valid), 1);
            if (c == 3) check("zw_inst_c3", inst, 32'h0050_0093);
            if (c == 5) check("zw_inst_held", inst, 32'h0050_0093);
        end
        check("zw_iv_count", iv_cnt, 1);

        // Wait states, with a stray data-valid during the address phase
        iv_cnt = 0;
        for (int c = 0; c <= 9; c++) begin
            drive(0, c == 0, 32'h200, c == 3, (c == 2) || (c == 7),
                  (c == 2) ? 32'hBAD0_BAD0 : 32'h1234_5678);
            if (c >= 1 && c <= 3) begin
                check("ws_addr_valid", 32'(ir_addr_valid), 1);
                check("ws_ir_addr", ir_addr, 32'h200);
            end
            if (c == 4) check("ws_stray_ignored", inst, 32'h0050_0093);
            if (inst_valid) begin
                iv_cnt++;
                check("ws_iv_cycle", c, 8);
                check("ws_inst", inst, 32'h1234_5678);
            end
        end
        check("ws_iv_count", iv_cnt, 1);

        // Misaligned request
        iv_cnt = 0; av_cnt = 0;
        for (int c = 0; c <= 4; c++) begin
            drive(0, c == 0, 32'h102, 1, 1, 32'hFFFF_FFFF);
            if (inst_valid) iv_cnt++;
            if (ir_addr_valid) av_cnt++;
            if (c == 1) check("mis_pulse", 32'(inst_misaligned), 1);
            if (c == 2) check("mis_pulse_end", 32'(inst_misaligned), 0);
        end
        check("mis_no_iv", iv_cnt, 0);
        check("mis_no_av", av_cnt, 0);
        check("mis_inst_kept", inst, 32'h1234_5678);

        // Overrun: second request lands in the data phase
        iv_cnt = 0; av_cnt = 0;
        for (int c = 0; c <= 8; c++) begin
            drive(0, (c == 0) || (c == 2), (c == 0) ? 32'h300 : 32'h400, c == 1, c == 3,
                  32'hCAFE_F00D);
            if (inst_valid) iv_cnt++;
            if (ir_addr_valid) av_cnt++;
            if (c >= 3) check("ovr_sticky", 32'(fetch_overrun), 1);
        end
        check("ovr_iv_count", iv_cnt, 1);
        check("ovr_av_count", av_cnt, 1);
        check("ovr_inst", inst, 32'hCAFE_F00D);
        check("ovr_ir_addr", ir_addr, 32'h300);

        // Reset in the data phase (with a simultaneous request), then a late data beat
        for (int c = 0; c <= 6; c++) begin
            drive(c == 2, (c == 0) || (c == 2), 32'h500, c == 1, c >= 3, 32'hDEAD_BEEF);
            if (c == 2) check("rm_in_data", 32'(ir_data_ready), 1);
            if (c >= 3) begin
                check("rm_inst", inst, 0);
                check("rm_iv", 32'(inst_valid), 0);
                check("rm_dr", 32'(ir_data_ready), 0);
                check("rm_av", 32'(ir_addr_valid), 0);
                check("rm_ir_addr", ir_addr, 0);
                check("rm_ovr", 32'(fetch_overrun), 0);
            end
        end

        // Back-to-back fetches at cycles 0 and 4
        iv_cnt = 0;
        for (int c = 0; c <= 8; c++) begin
            drive(0, (c == 0) || (c == 4), (c == 0) ? 32'h0 : 32'h4, 1, 1,
                  (c < 4) ? 32'hA1A1_0001 : 32'hB2B2_0002);
            if (inst_valid) iv_cnt++;
            if (c == 3) check("b2b_iv_c3", 32'(inst_valid), 1);
            if (c == 3) check("b2b_inst_c3", inst, 32'hA1A1_0001);
            if (c == 5) check("b2b_ir_addr", ir_addr, 32'h4);
            if (c == 7) check("b2b_iv_c7", 32'(inst_valid), 1);
            if (c == 7) check("b2b_inst_c7", inst, 32'hB2B2_0002);
        end
        check("b2b_iv_count", iv_cnt, 2);
        check("b2b_no_ovr", 32'(fetch_overrun), 0);

        drive(0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
